// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: shares one alu_core between the main pipeline (req0) and
// the auxiliary/MAC unit (req1). Round-robin grant, per-requester dependency
// scoreboard, registered operand/control issue, and a tag pipe that routes
// each P result back to the requester that issued it.
module alu_issue_arbiter #(
    parameter int unsigned P_LATENCY = 4,
    parameter int unsigned P_CNTW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic        req0_dep_i,
    input  logic [29:0] req0_a_i,
    input  logic [17:0] req0_b_i,
    input  logic [47:0] req0_c_i,
    input  logic [16:0] req0_ctl_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic        req1_dep_i,
    input  logic [29:0] req1_a_i,
    input  logic [17:0] req1_b_i,
    input  logic [47:0] req1_c_i,
    input  logic [16:0] req1_ctl_i,
    input  logic        drain_i,
    output logic        drain_done_o,
    output logic [29:0] alu_a_o,
    output logic [17:0] alu_b_o,
    output logic [47:0] alu_c_o,
    output logic [3:0]  alu_alumode_o,
    output logic [4:0]  alu_inmode_o,
    output logic [6:0]  alu_opmode_o,
    output logic        alu_usemult_o,
    output logic        alu_ce_o,
    input  logic [47:0] p_i,
    output logic        rsp0_valid_o,
    output logic        rsp1_valid_o,
    output logic [47:0] rsp_p_o
);

    localparam int unsigned       TAG_LEN = P_LATENCY + 1;
    localparam logic [P_CNTW-1:0] CNT_ONE = P_CNTW'(1);

    logic [P_CNTW-1:0]  cnt_0;
    logic [P_CNTW-1:0]  cnt_1;
    logic               last_grant;
    logic [TAG_LEN-1:0] tag_v;
    logic [TAG_LEN-1:0] tag_id;

    logic        elig_0;
    logic        elig_1;
    logic        grant_0;
    logic        grant_1;
    logic        accept;
    logic        tail_0;
    logic        tail_1;
    logic [29:0] sel_a;
    logic [17:0] sel_b;
    logic [47:0] sel_c;
    logic [16:0] sel_ctl;

    // Eligibility, round-robin grant and operand select for the winner
    always_comb begin
        elig_0  = req0_valid_i & ~drain_i & ~(req0_dep_i & (cnt_0 != '0)) & ~rst;
        elig_1  = req1_valid_i & ~drain_i & ~(req1_dep_i & (cnt_1 != '0)) & ~rst;
        // last_grant==1 means req1 won last time, so req0 takes a conflict
        grant_0 = elig_0 & (~elig_1 | last_grant);
        grant_1 = elig_1 & (~elig_0 | ~last_grant);
        accept  = grant_0 | grant_1;
        sel_a   = grant_1 ? req1_a_i   : req0_a_i;
        sel_b   = grant_1 ? req1_b_i   : req0_b_i;
        sel_c   = grant_1 ? req1_c_i   : req0_c_i;
        sel_ctl = grant_1 ? req1_ctl_i : req0_ctl_i;
    end

    // Response routing from the tail of the tag pipe
    always_comb begin
        tail_0       = tag_v[P_LATENCY] & ~tag_id[P_LATENCY];
        tail_1       = tag_v[P_LATENCY] &  tag_id[P_LATENCY];
        rsp0_valid_o = tail_0 & ~rst;
        rsp1_valid_o = tail_1 & ~rst;
        rsp_p_o      = p_i;
        req0_ready_o = grant_0;
        req1_ready_o = grant_1;
        drain_done_o = drain_i & ~rst & (cnt_0 == '0) & (cnt_1 == '0);
    end

    // Round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant_1;
        end
    end

    // Issue register: operands hold between issues, controls return to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_o       <= '0;
            alu_b_o       <= '0;
            alu_c_o       <= '0;
            alu_alumode_o <= '0;
            alu_inmode_o  <= '0;
            alu_opmode_o  <= '0;
            alu_usemult_o <= 1'b0;
            alu_ce_o      <= 1'b0;
        end else if (accept) begin
            alu_a_o       <= sel_a;
            alu_b_o       <= sel_b;
            alu_c_o       <= sel_c;
            alu_usemult_o <= sel_ctl[16];
            alu_alumode_o <= sel_ctl[15:12];
            alu_inmode_o  <= sel_ctl[11:7];
            alu_opmode_o  <= sel_ctl[6:0];
            alu_ce_o      <= 1'b1;
        end else begin
            alu_alumode_o <= '0;
            alu_inmode_o  <= '0;
            alu_opmode_o  <= '0;
            alu_usemult_o <= 1'b0;
            alu_ce_o      <= 1'b0;
        end
    end

    // Tag pipe: one stage per cycle of issue + alu_core latency
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v  <= {tag_v[TAG_LEN-2:0], accept};
            tag_id <= {tag_id[TAG_LEN-2:0], grant_1};
        end
    end

    // In-flight counters; accept and response in the same cycle cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_0 <= '0;
            cnt_1 <= '0;
        end else begin
            if (grant_0 & ~tail_0) begin
                cnt_0 <= cnt_0 + CNT_ONE;
            end else if (~grant_0 & tail_0) begin
                cnt_0 <= cnt_0 - CNT_ONE;
            end
            if (grant_1 & ~tail_1) begin
                cnt_1 <= cnt_1 + CNT_ONE;
            end else if (~grant_1 & tail_1) begin
                cnt_1 <= cnt_1 - CNT_ONE;
            end
        end
    end

endmodule
